// File: rtl/dpu_pio_pkg.sv
// Shared PIO definitions for the dpu_top command port and its host-side sequencers.
package dpu_pio_pkg;

    localparam int PIO_ADDR_W = 24;

    // Address map of the DPU PIO space
    localparam int MAX_WBUF  = 147456;
    localparam int MAX_CH    = 256;
    localparam int BIAS_BASE = MAX_WBUF;
    localparam int FMAP_BASE = MAX_WBUF + MAX_CH * 4;

    typedef enum logic [2:0] {
        WRITE      = 3'd0,
        RUN_LAYER  = 3'd1,
        READ       = 3'd2,
        SET_LAYER  = 3'd3,
        RUN_ALL    = 3'd4,
        SCALE      = 3'd5,
        LAYER_DESC = 3'd6
    } pio_cmd_e;

    function automatic logic is_burst(input pio_cmd_e t);
        return (t == WRITE) || (t == READ);
    endfunction

endpackage

// File: rtl/dpu_pio_burst_master_if.sv
// Descriptor, payload stream, response stream and PIO command/response signals of the burst master.
interface dpu_pio_burst_master_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 24
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [7:0]        req_data;

    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;

    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_data;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_data;

    logic              rsp_valid;
    logic [7:0]        rsp_data;

    modport master (
        input  req_valid, req_type, req_addr, req_len, req_data,
        output req_ready,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data,
        input  m_ready,
        output cmd_valid, cmd_type, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_type, req_addr, req_len, req_data,
        input  req_ready,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data,
        output m_ready,
        input  cmd_valid, cmd_type, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/dpu_pio_burst_master_rsp_timer.sv
// Loadable down-counter bounding the wait for a PIO read response.
module pio_rsp_timer #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Loaded with CYCLES-1 so expiry lands on the CYCLES-th cycle after the load edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dpu_pio_burst_master.sv
// Turns one burst descriptor into a sequence of single-byte PIO commands with auto-incrementing address.
module dpu_pio_burst_master
    import dpu_pio_pkg::*;
#(
    parameter int LEN_W       = 24,
    parameter int RSP_TIMEOUT = 1024,
    parameter int ADDR_W      = PIO_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    dpu_pio_burst_master_if.master bus,
    output logic             busy,
    output logic             burst_done,
    output logic             err_timeout,
    output logic [LEN_W-1:0] bytes_done
);

    // state      | meaning
    // S_IDLE     | waiting for a descriptor, req_ready high
    // S_FETCH    | pulling the next write byte from the payload stream
    // S_ISSUE    | PIO command presented, waiting for cmd_ready
    // S_RSP_WAIT | read issued, waiting for rsp_valid or timeout
    // S_RSP_OUT  | read byte presented on the response stream
    // S_DONE     | one-cycle burst_done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_RSP_WAIT, S_RSP_OUT, S_DONE
    } state_e;

    state_e            state_q;
    pio_cmd_e          type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bytes_done_q;
    logic [7:0]        cmd_data_q;
    logic [7:0]        m_data_q;
    logic              req_ready_q;
    logic              s_ready_q;
    logic              cmd_valid_q;
    logic              m_valid_q;
    logic              busy_q;
    logic              burst_done_q;
    logic              err_q;

    pio_cmd_e          req_type_e;
    logic [LEN_W-1:0]  bytes_inc_d;
    logic [ADDR_W-1:0] addr_inc_d;
    logic              cmd_hs;
    logic              timer_load;
    logic              timer_expired;

    assign req_type_e  = pio_cmd_e'(bus.req_type);
    assign bytes_inc_d = bytes_done_q + LEN_W'(1);
    assign addr_inc_d  = addr_q + ADDR_W'(1);
    assign cmd_hs      = (state_q == S_ISSUE) && cmd_valid_q && bus.cmd_ready;
    assign timer_load  = cmd_hs && (type_q == READ);

    pio_rsp_timer #(.CYCLES(RSP_TIMEOUT)) u_rsp_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .en_i      (state_q == S_RSP_WAIT),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            type_q       <= WRITE;
            addr_q       <= '0;
            len_q        <= '0;
            bytes_done_q <= '0;
            cmd_data_q   <= '0;
            m_data_q     <= '0;
            req_ready_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        type_q       <= req_type_e;
                        addr_q       <= bus.req_addr;
                        len_q        <= bus.req_len;
                        cmd_data_q   <= bus.req_data;
                        bytes_done_q <= '0;
                        err_q        <= 1'b0;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (!is_burst(req_type_e)) begin
                            len_q       <= LEN_W'(1);
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end else if (bus.req_len == '0) begin
                            burst_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else if (req_type_e == WRITE) begin
                            s_ready_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.s_valid && s_ready_q) begin
                        cmd_data_q  <= bus.s_data;
                        s_ready_q   <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_hs) begin
                        cmd_valid_q <= 1'b0;
                        if (type_q == READ) begin
                            state_q <= S_RSP_WAIT;
                        end else begin
                            bytes_done_q <= bytes_inc_d;
                            addr_q       <= addr_inc_d;
                            if ((bytes_inc_d == len_q) || (type_q != WRITE)) begin
                                burst_done_q <= 1'b1;
                                state_q      <= S_DONE;
                            end else begin
                                s_ready_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end
                        end
                    end
                end
                S_RSP_WAIT: begin
                    // A response arriving on the expiry cycle still counts
                    if (bus.rsp_valid) begin
                        m_data_q  <= bus.rsp_data;
                        m_valid_q <= 1'b1;
                        state_q   <= S_RSP_OUT;
                    end else if (timer_expired) begin
                        err_q        <= 1'b1;
                        burst_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_RSP_OUT: begin
                    if (m_valid_q && bus.m_ready) begin
                        m_valid_q    <= 1'b0;
                        bytes_done_q <= bytes_inc_d;
                        addr_q       <= addr_inc_d;
                        if (bytes_inc_d == len_q) begin
                            burst_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_type  = type_q;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_data  = cmd_data_q;

    assign busy        = busy_q;
    assign burst_done  = burst_done_q;
    assign err_timeout = err_q;
    assign bytes_done  = bytes_done_q;

endmodule

// File: tb/tb_dpu_pio_burst_master.sv
// Directed bench for dpu_pio_burst_master with a 2-cycle-latency PIO responder and stream models.
module tb_dpu_pio_burst_master;
    import dpu_pio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, burst_done, err_timeout;
    logic [23:0] bytes_done;

    always #5 clk = ~clk;

    dpu_pio_burst_master_if #(.ADDR_W(24), .LEN_W(24)) bus ();

    dpu_pio_burst_master #(.LEN_W(24), .RSP_TIMEOUT(16), .ADDR_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .busy        (busy),
        .burst_done  (burst_done),
        .err_timeout (err_timeout),
        .bytes_done  (bytes_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0]  log_type [32];
    logic [23:0] log_addr [32];
    logic [7:0]  log_data [32];
    int          cmd_n, cmd_seen, cmd_hs_cyc;
    logic [7:0]  s_buf [16];
    int          s_idx, s_n, sready_seen;
    logic [7:0]  m_log [16];
    int          m_n, stall_byte, stall_left, overlap;
    int          rsp_cnt;
    logic [7:0]  rsp_val;
    bit          rsp_en, pio_ready_en, req_pend, err_prev;
    int          done_cnt, done_cyc, acc_cyc, err_rise;

    // One negedge: drive inputs for the coming posedge and record handshakes that it will complete
    task automatic step();
        @(negedge clk);
        cyc++;
        if (req_pend) begin
            bus.req_valid = 1'b0;
            req_pend = 1'b0;
        end
        bus.rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rsp_val;
                rsp_val++;
            end
        end
        bus.cmd_ready = pio_ready_en;
        if (bus.cmd_valid) cmd_seen++;
        if (bus.cmd_valid && bus.cmd_ready) begin
            if (cmd_n < 32) begin
                log_type[cmd_n] = bus.cmd_type;
                log_addr[cmd_n] = bus.cmd_addr;
                log_data[cmd_n] = bus.cmd_data;
            end
            cmd_n++;
            cmd_hs_cyc = cyc;
            if (bus.cmd_type == 3'd2 && rsp_en) rsp_cnt = 2;
        end
        bus.s_valid = (s_idx < s_n);
        bus.s_data  = (s_idx < 16) ? s_buf[s_idx] : 8'h00;
        if (bus.s_ready) sready_seen++;
        if (bus.s_valid && bus.s_ready) s_idx++;
        if (bus.m_valid && m_n == stall_byte && stall_left > 0) begin
            bus.m_ready = 1'b0;
            stall_left--;
        end else begin
            bus.m_ready = 1'b1;
        end
        if (bus.m_valid && bus.m_ready) begin
            if (m_n < 16) m_log[m_n] = bus.m_data;
            m_n++;
        end
        if (bus.m_valid && bus.cmd_valid) overlap++;
        if (burst_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_timeout && !err_prev) err_rise = cyc;
        err_prev = err_timeout;
        if (bus.req_valid && bus.req_ready) begin
            req_pend = 1'b1;
            acc_cyc  = cyc;
        end
    endtask

    task automatic clear_model();
        cmd_n = 0; cmd_seen = 0; cmd_hs_cyc = 0;
        s_idx = 0; s_n = 0; sready_seen = 0;
        m_n = 0; stall_byte = -1; stall_left = 0; overlap = 0;
        rsp_cnt = 0; rsp_val = 8'h00; rsp_en = 1'b1; pio_ready_en = 1'b1;
        done_cnt = 0; done_cyc = 0; acc_cyc = 0; err_rise = -1;
    endtask

    task automatic send_req(input logic [2:0] t, input logic [23:0] a, input logic [23:0] l,
                            input logic [7:0] d);
        int n = 0;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_data  = d;
        bus.req_valid = 1'b1;
        if (bus.req_ready) begin
            req_pend = 1'b1;
            acc_cyc  = cyc;
        end
        while (!req_pend && n < 20) begin
            step();
            n++;
        end
        total++;
        if (!req_pend) begin
            bad++;
            $display("FAIL req_accept: descriptor type %0d not accepted within 20 cycles", t);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int max, input string name);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < max) begin
            step();
            n++;
        end
        total++;
        if (done_cnt == start) begin
            bad++;
            $display("FAIL %s_done: burst_done not seen within %0d cycles", name, max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++;
        if ({bus.req_ready, bus.s_ready, bus.m_valid, bus.cmd_valid, busy, burst_done, err_timeout} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                {bus.req_ready, bus.s_ready, bus.m_valid, bus.cmd_valid, busy, burst_done, err_timeout});
        end
        total++;
        if ({bus.cmd_type, bus.cmd_addr, bus.cmd_data, bus.m_data, bytes_done} !== '0) begin
            bad++;
            $display("FAIL reset_data: type=%0d addr=%h data=%h m=%h bytes=%0d want all 0",
                bus.cmd_type, bus.cmd_addr, bus.cmd_data, bus.m_data, bytes_done);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_write_burst();
        clear_model();
        s_buf[0] = 8'hA1; s_buf[1] = 8'hB2; s_buf[2] = 8'hC3; s_n = 3;
        send_req(3'd0, 24'h024400, 24'd3, 8'h00);
        wait_done(60, "write");
        repeat (4) step();
        total++;
        if (cmd_n !== 3) begin
            bad++;
            $display("FAIL write_count: got %0d cmds want 3", cmd_n);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_type[i] !== 3'd0 || log_addr[i] !== 24'h024400 + 24'(i) || log_data[i] !== s_buf[i]) begin
                bad++;
                $display("FAIL write_cmd%0d: got type=%0d addr=%h data=%h want type=0 addr=%h data=%h",
                    i, log_type[i], log_addr[i], log_data[i], 24'h024400 + 24'(i), s_buf[i]);
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL write_done_pulses: got %0d want 1", done_cnt);
        end
        total++;
        if (bytes_done !== 24'd3) begin
            bad++;
            $display("FAIL write_bytes_done: got %0d want 3", bytes_done);
        end
    endtask

    task automatic test_read_burst();
        clear_model();
        rsp_val = 8'h10;
        stall_byte = 1; stall_left = 5;
        send_req(3'd2, 24'h000000, 24'd4, 8'h00);
        wait_done(100, "read");
        step();
        total++;
        if (m_n !== 4) begin
            bad++;
            $display("FAIL read_count: got %0d bytes want 4", m_n);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m_log[i] !== 8'h10 + 8'(i) || log_addr[i] !== 24'(i) || log_type[i] !== 3'd2) begin
                bad++;
                $display("FAIL read_byte%0d: got m=%h addr=%h type=%0d want m=%h addr=%h type=2",
                    i, m_log[i], log_addr[i], log_type[i], 8'h10 + 8'(i), 24'(i));
            end
        end
        total++;
        if (overlap !== 0 || stall_left !== 0) begin
            bad++;
            $display("FAIL read_overlap: got overlap=%0d stall_left=%0d want 0/0", overlap, stall_left);
        end
        total++;
        if (bytes_done !== 24'd4) begin
            bad++;
            $display("FAIL read_bytes_done: got %0d want 4", bytes_done);
        end
    endtask

    task automatic test_single();
        clear_model();
        send_req(3'd4, 24'h000123, 24'd0, 8'h00);
        wait_done(20, "single");
        step();
        total++;
        if (cmd_n !== 1 || log_type[0] !== 3'd4 || log_data[0] !== 8'h00 || log_addr[0] !== 24'h000123) begin
            bad++;
            $display("FAIL single_cmd: got n=%0d type=%0d data=%h addr=%h want 1/4/00/000123",
                cmd_n, log_type[0], log_data[0], log_addr[0]);
        end
        total++;
        if (bytes_done !== 24'd1 || sready_seen !== 0) begin
            bad++;
            $display("FAIL single_bytes: got bytes=%0d s_ready_cycles=%0d want 1/0", bytes_done, sready_seen);
        end
    endtask

    task automatic test_zero_len();
        clear_model();
        send_req(3'd0, 24'h000040, 24'd0, 8'h00);
        wait_done(10, "zero_len");
        repeat (3) step();
        total++;
        if (done_cyc - acc_cyc > 2 || done_cyc <= acc_cyc) begin
            bad++;
            $display("FAIL zero_len_latency: got %0d cycles want 1..2", done_cyc - acc_cyc);
        end
        total++;
        if (cmd_seen !== 0 || sready_seen !== 0) begin
            bad++;
            $display("FAIL zero_len_traffic: got cmd_valid_cycles=%0d s_ready_cycles=%0d want 0/0",
                cmd_seen, sready_seen);
        end
    endtask

    task automatic test_timeout();
        clear_model();
        rsp_en = 1'b0;
        send_req(3'd2, 24'h000010, 24'd1, 8'h00);
        wait_done(60, "timeout");
        step();
        // cmd_hs_cyc is the negedge before the handshake edge, err is seen the negedge after edge +16
        total++;
        if (err_rise - cmd_hs_cyc !== 17) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want 17 (16 cycles after handshake)", err_rise - cmd_hs_cyc);
        end
        total++;
        if (err_timeout !== 1'b1 || bytes_done !== 24'd0 || done_cnt !== 1 || m_n !== 0) begin
            bad++;
            $display("FAIL timeout_state: got err=%b bytes=%0d done=%0d m=%0d want 1/0/1/0",
                err_timeout, bytes_done, done_cnt, m_n);
        end
        send_req(3'd3, 24'h000002, 24'd0, 8'h07);
        step();
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: got err=%b want 0", err_timeout);
        end
        wait_done(20, "timeout_next");
    endtask

    task automatic test_reset_and_wrap();
        int n = 0;
        clear_model();
        pio_ready_en = 1'b0;
        for (int i = 0; i < 10; i++) s_buf[i] = 8'(8'h30 + i);
        s_n = 10;
        send_req(3'd0, 24'h000050, 24'd10, 8'h00);
        while (!bus.cmd_valid && n < 20) begin
            step();
            n++;
        end
        total++;
        if (bus.cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset_setup: cmd_valid got %b want 1", bus.cmd_valid);
        end
        rst = 1'b1;
        s_n = 0;
        step();
        total++;
        if ({bus.req_ready, bus.s_ready, bus.m_valid, bus.cmd_valid, busy, burst_done, err_timeout,
             bus.cmd_addr, bus.cmd_data, bytes_done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got valid=%b s=%b busy=%b addr=%h data=%h bytes=%0d want 0",
                bus.cmd_valid, bus.s_ready, busy, bus.cmd_addr, bus.cmd_data, bytes_done);
        end
        rst = 1'b0;
        step();
        total++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ready: got req_ready=%b busy=%b want 1/0", bus.req_ready, busy);
        end
        clear_model();
        s_buf[0] = 8'h55; s_buf[1] = 8'h66; s_n = 2;
        send_req(3'd0, 24'hFFFFFF, 24'd2, 8'h00);
        wait_done(40, "wrap");
        step();
        total++;
        if (cmd_n !== 2 || log_addr[0] !== 24'hFFFFFF || log_addr[1] !== 24'h000000 ||
            log_data[0] !== 8'h55 || log_data[1] !== 8'h66) begin
            bad++;
            $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h d0=%h d1=%h want 2/FFFFFF/000000/55/66",
                cmd_n, log_addr[0], log_addr[1], log_data[0], log_data[1]);
        end
        total++;
        if (bytes_done !== 24'd2) begin
            bad++;
            $display("FAIL wrap_bytes_done: got %0d want 2", bytes_done);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_type = 3'd0; bus.req_addr = '0; bus.req_len = '0; bus.req_data = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
        bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
        req_pend = 1'b0; err_prev = 1'b0;
        clear_model();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_single();
        test_zero_len();
        test_timeout();
        test_reset_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
